seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_disp_pkg.sv | 56 +++++
 rtl/seg_bin2bcd.sv | 86 ++++++++
 rtl/seg_scan_display.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display: active-low glyphs
// (bit 6 = g .. bit 0 = a), digit-count limits and converter state encoding.
package seg_disp_pkg;

    localparam int unsigned NDIGITS_MIN = 1;
    localparam int unsigned NDIGITS_MAX = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_DONE
    } cv_state_e;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter: one bit per cycle, then a
// single DONE cycle presenting the result; overflow is sticky past NDIGITS digits.
module seg_bin2bcd
    import seg_disp_pkg::*;
#(
    parameter int unsigned BIN_W   = 16,
    parameter int unsigned NDIGITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [BIN_W-1:0]     bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NDIGITS-1:0] bcd_o,
    output logic                 ovf_o
);

    localparam int unsigned DW = 4 * NDIGITS;
    localparam int unsigned CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    cv_state_e        state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    adj;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CV_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        adj     = '0;
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                       : bcd_q[4*k +: 4];
        end
        case (state_q)
            CV_IDLE: begin
                if (start_i) begin
                    state_d = CV_SHIFT;
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            CV_SHIFT: begin
                // The bit shifted out of the top digit is exactly the 10^NDIGITS carry.
                bcd_d = {adj[DW-2:0], bin_q[BIN_W-1]};
                ovf_d = ovf_q | adj[DW-1];
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = CV_DONE;
                end
            end
            CV_DONE: state_d = CV_IDLE;
            default: state_d = CV_IDLE;
        endcase
    end

    assign busy_o = (state_q != CV_IDLE);
    assign done_o = (state_q == CV_DONE);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with hex/decimal shadow register.
// Define SEGDISP_BCD_EN to build the decimal (double-dabble) path; otherwise hex only.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int unsigned NDIGITS     = 4,
    parameter int unsigned REFRESH_DIV = 262144,
    parameter int unsigned BIN_W       = 4 * NDIGITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BIN_W-1:0]   value,
    input  logic               dec_mode,
    input  logic [NDIGITS-1:0] dp_mask,
    input  logic               blank_lz,
    output logic               busy,
    output logic [NDIGITS-1:0] anode_n,
    output logic [6:0]         seg_n,
    output logic               dp_n
);

    localparam int unsigned DW    = 4 * NDIGITS;
    localparam int unsigned EXT_W = (BIN_W > DW) ? BIN_W : DW;
    localparam int unsigned RW    = $clog2(REFRESH_DIV);
    localparam int unsigned IW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    if (NDIGITS < NDIGITS_MIN || NDIGITS > NDIGITS_MAX) begin : g_bad_ndigits
        $error("seg_scan_display: NDIGITS out of range");
    end

    logic [NDIGITS-1:0][3:0] dig_q, dig_d;
    logic                    ovf_q, ovf_d;
    logic [NDIGITS-1:0]      dp_q, dp_d;
    logic                    blz_q, blz_d;
    logic [RW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NDIGITS-1:0]      anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpn_q, dpn_d;

    logic [EXT_W-1:0]        value_ext;
    logic                    accept;
    logic [NDIGITS-1:0]      lz_blank;
    logic                    zero_run;

    assign value_ext = EXT_W'(value);
    assign accept    = load & ~busy;

`ifdef SEGDISP_BCD_EN
    logic               cv_done;
    logic               cv_ovf;
    logic [DW-1:0]      cv_bcd;
    logic [NDIGITS-1:0] pend_dp_q;
    logic               pend_blz_q;

    seg_bin2bcd #(
        .BIN_W   (BIN_W),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_i   (reset),
        .start_i (accept & dec_mode),
        .bin_i   (value),
        .busy_o  (busy),
        .done_o  (cv_done),
        .bcd_o   (cv_bcd),
        .ovf_o   (cv_ovf)
    );

    // Attributes captured at load are held back so they commit with the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dp_q  <= '0;
            pend_blz_q <= 1'b0;
        end else if (accept && dec_mode) begin
            pend_dp_q  <= dp_mask;
            pend_blz_q <= blank_lz;
        end
    end

    always_comb begin
        dig_d = dig_q;
        ovf_d = ovf_q;
        dp_d  = dp_q;
        blz_d = blz_q;
        if (cv_done) begin
            dig_d = cv_bcd;
            ovf_d = cv_ovf;
            dp_d  = pend_dp_q;
            blz_d = pend_blz_q;
        end else if (accept && !dec_mode) begin
            dig_d = value_ext[DW-1:0];
            ovf_d = 1'b0;
            dp_d  = dp_mask;
            blz_d = blank_lz;
        end
    end
`else
    logic unused_dec_mode;
    assign unused_dec_mode = dec_mode;
    assign busy            = 1'b0;

    always_comb begin
        dig_d = dig_q;
        ovf_d = ovf_q;
        dp_d  = dp_q;
        blz_d = blz_q;
        if (accept) begin
            dig_d = value_ext[DW-1:0];
            ovf_d = 1'b0;
            dp_d  = dp_mask;
            blz_d = blank_lz;
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q + RW'(1);
        idx_d = idx_q;
        if (cnt_q == RW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == '0) ? IW'(NDIGITS - 1) : idx_q - IW'(1);
        end
    end

    // Walk from the MSD down; a digit blanks while every digit at or above it is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            zero_run                 = zero_run & (dig_q[NDIGITS-1-i] == 4'd0);
            lz_blank[NDIGITS-1-i]    = zero_run & (i != NDIGITS - 1);
        end
    end

    always_comb begin
        anode_d = ~(NDIGITS'(1) << idx_q);
        dpn_d   = ~dp_q[idx_q];
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blz_q && lz_blank[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = hex_glyph(dig_q[idx_q]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= IW'(NDIGITS - 1);
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
            dpn_q   <= 1'b1;
        end else begin
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            dp_q    <= dp_d;
            blz_q   <= blz_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dpn_q   <= dpn_d;
        end
    end

    assign anode_n = anode_q;
    assign seg_n   = seg_q;
    assign dp_n    = dpn_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (NDIGITS=4, REFRESH_DIV=4, BIN_W=16);
// decimal-mode scenarios are exercised when SEGDISP_BCD_EN is defined.
module tb_seg_scan_display;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [BW-1:0] value;
    logic          dec_mode;
    logic [ND-1:0] dp_mask;
    logic          blank_lz;
    logic          busy;
    logic [ND-1:0] anode_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model: what the display should currently be showing.
    int unsigned m_val;
    bit          m_dec;
    bit [ND-1:0] m_dp;
    bit          m_blz;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NDIGITS     (ND),
        .REFRESH_DIV (RD),
        .BIN_W       (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dec_mode (dec_mode),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .busy     (busy),
        .anode_n  (anode_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    function automatic logic [6:0] ref_glyph(input int unsigned d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned k);
        int unsigned base;
        int unsigned p;
        base = m_dec ? 10 : 16;
        p    = 1;
        for (int unsigned i = 0; i < k; i++) p = p * base;
        if (m_dec && m_val > 9999) return 7'b0111111;
        if (m_blz && k > 0 && m_val < p) return 7'b1111111;
        return ref_glyph((m_val / p) % base);
    endfunction

    function automatic int active_digit(input logic [ND-1:0] an);
        int zeros;
        int idx;
        zeros = 0;
        idx   = -1;
        for (int i = 0; i < ND; i++) begin
            if (an[i] === 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    // Present one load strobe; returns at the negedge just after the capturing edge.
    task automatic drive_load(input logic [BW-1:0] v, input logic dm,
                              input logic [ND-1:0] dpm, input logic blz);
        value    = v;
        dec_mode = dm;
        dp_mask  = dpm;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        int unsigned exp_k;
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dec_mode = 1'b0;
        dp_mask  = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (anode_n !== 4'b1111) begin errors++; $display("FAIL reset_anode got=%b exp=1111", anode_n); end
        vectors++;
        if (seg_n !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg_n); end
        vectors++;
        if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        m_val = 0; m_dec = 1'b0; m_dp = '0; m_blz = 1'b0;
        for (int unsigned n = 1; n <= 24; n++) begin
            @(negedge clk);
            exp_k = 3 - (((n - 1) / RD) % ND);
            vectors++;
            if (anode_n !== ~(4'b0001 << exp_k)) begin
                errors++;
                $display("FAIL scan_order cyc=%0d got=%b exp=%b", n, anode_n, ~(4'b0001 << exp_k));
            end
            vectors++;
            if (seg_n !== 7'b1000000) begin errors++; $display("FAIL scan_seg cyc=%0d got=%b exp=1000000", n, seg_n); end
            vectors++;
            if (dp_n !== 1'b1) begin errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", n, dp_n); end
        end
    endtask

    task automatic test_hex;
        logic [BW-1:0] v;
        logic [ND-1:0] dpm;
        logic          blz;
        int            k;
        for (int unsigned t = 0; t < 8; t++) begin
            case (t)
                0:       begin v = 16'hA3F0; dpm = 4'b0100; blz = 1'b0; end
                1:       begin v = 16'h0007; dpm = 4'b0000; blz = 1'b1; end
                2:       begin v = 16'h0000; dpm = 4'b1001; blz = 1'b1; end
                default: begin v = 16'($urandom); dpm = 4'($urandom); blz = 1'($urandom); end
            endcase
            if (t == 7) v = v & 16'h00FF;
            drive_load(v, 1'b0, dpm, blz);
            m_val = v; m_dec = 1'b0; m_dp = dpm; m_blz = blz;
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL hex_busy t=%0d got=%b exp=0", t, busy); end
            repeat (2) @(negedge clk);
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                k = active_digit(anode_n);
                vectors++;
                if (k < 0) begin
                    errors++;
                    $display("FAIL hex_onehot t=%0d got=%b exp=one-low", t, anode_n);
                end else begin
                    vectors++;
                    if (seg_n !== exp_seg(k)) begin
                        errors++;
                        $display("FAIL hex_seg val=%h dig=%0d got=%b exp=%b", v, k, seg_n, exp_seg(k));
                    end
                    vectors++;
                    if (dp_n !== ~m_dp[k]) begin
                        errors++;
                        $display("FAIL hex_dp val=%h dig=%0d got=%b exp=%b", v, k, dp_n, ~m_dp[k]);
                    end
                end
            end
        end
    endtask

`ifdef SEGDISP_BCD_EN
    task automatic test_decimal;
        logic [BW-1:0] v;
        logic [ND-1:0] dpm;
        logic          blz;
        int            k;
        for (int unsigned t = 0; t < 9; t++) begin
            case (t)
                0:       begin v = 16'd1234;  dpm = 4'b0000; blz = 1'b0; end
                1:       begin v = 16'd12345; dpm = 4'b0100; blz = 1'b1; end
                2:       begin v = 16'd9999;  dpm = 4'b0001; blz = 1'b0; end
                3:       begin v = 16'd10000; dpm = 4'b0000; blz = 1'b1; end
                4:       begin v = 16'd0;     dpm = 4'b0000; blz = 1'b1; end
                5:       begin v = 16'd40;    dpm = 4'b0010; blz = 1'b1; end
                default: begin
                    v   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(10000, 65535))
                                                      : 16'($urandom_range(0, 9999));
                    dpm = 4'($urandom);
                    blz = 1'($urandom);
                end
            endcase
            drive_load(v, 1'b1, dpm, blz);
            for (int unsigned i = 0; i < BW + 1; i++) begin
                if (i > 0) @(negedge clk);
                if (i == 5) begin
                    value = 16'h5555; dec_mode = 1'b0; dp_mask = 4'hF; blank_lz = 1'b0; load = 1'b1;
                end else begin
                    load = 1'b0;
                end
                vectors++;
                if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy_high val=%0d cyc=%0d got=%b exp=1", v, i, busy); end
                k = active_digit(anode_n);
                if (k >= 0) begin
                    vectors++;
                    if (seg_n !== exp_seg(k)) begin
                        errors++;
                        $display("FAIL dec_atomic val=%0d dig=%0d got=%b exp=%b", v, k, seg_n, exp_seg(k));
                    end
                end
            end
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL dec_busy_fall val=%0d got=%b exp=0", v, busy); end
            m_val = v; m_dec = 1'b1; m_dp = dpm; m_blz = blz;
            repeat (2) @(negedge clk);
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                k = active_digit(anode_n);
                vectors++;
                if (k < 0) begin
                    errors++;
                    $display("FAIL dec_onehot val=%0d got=%b exp=one-low", v, anode_n);
                end else begin
                    vectors++;
                    if (seg_n !== exp_seg(k)) begin
                        errors++;
                        $display("FAIL dec_seg val=%0d dig=%0d got=%b exp=%b", v, k, seg_n, exp_seg(k));
                    end
                    vectors++;
                    if (dp_n !== ~m_dp[k]) begin
                        errors++;
                        $display("FAIL dec_dp val=%0d dig=%0d got=%b exp=%b", v, k, dp_n, ~m_dp[k]);
                    end
                end
            end
        end
    endtask
`else
    task automatic test_no_bcd;
        int k;
        drive_load(16'h0012, 1'b1, 4'b0000, 1'b0);
        m_val = 32'h12; m_dec = 1'b0; m_dp = '0; m_blz = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL nobcd_busy cyc=%0d got=%b exp=0", i, busy); end
            @(negedge clk);
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            k = active_digit(anode_n);
            vectors++;
            if (k < 0) begin
                errors++;
                $display("FAIL nobcd_onehot got=%b exp=one-low", anode_n);
            end else begin
                vectors++;
                if (seg_n !== exp_seg(k)) begin
                    errors++;
                    $display("FAIL nobcd_seg dig=%0d got=%b exp=%b", k, seg_n, exp_seg(k));
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        int k;
        drive_load(16'd4321, 1'b1, 4'b1111, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        vectors++;
        if (anode_n !== 4'b1111) begin errors++; $display("FAIL rstmid_anode got=%b exp=1111", anode_n); end
        vectors++;
        if (seg_n !== 7'b1111111) begin errors++; $display("FAIL rstmid_seg got=%b exp=1111111", seg_n); end
        reset = 1'b0;
        m_val = 0; m_dec = 1'b0; m_dp = '0; m_blz = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after cyc=%0d got=%b exp=0", n, busy); end
            k = active_digit(anode_n);
            vectors++;
            if (k < 0) begin
                errors++;
                $display("FAIL rstmid_onehot cyc=%0d got=%b exp=one-low", n, anode_n);
            end else begin
                vectors++;
                if (seg_n !== exp_seg(k)) begin
                    errors++;
                    $display("FAIL rstmid_seg dig=%0d got=%b exp=%b", k, seg_n, exp_seg(k));
                end
                vectors++;
                if (dp_n !== 1'b1) begin errors++; $display("FAIL rstmid_dp dig=%0d got=%b exp=1", k, dp_n); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
`ifdef SEGDISP_BCD_EN
        test_decimal();
`else
        test_no_bcd();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
